morse_tx: RTL and testbench

- Morse transmitter: accepts one letter code (A–Z) and produces the timed on/off keying waveform for it on key_out.
- It is the transmit counterpart to the decoder path, which measures press durations with up/down counters.
- Sits between the character source (keypad or UART front end) and the LED/buzzer driver.
- All timing is counted in Morse units, each marked by a one-cycle tick strobe from the shared prescaler.

---
 rtl/morse_tx.sv | 166 ++++++++++++++++
 tb/tb_morse_tx.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/morse_tx.sv
// Morse transmitter: turns one letter index (A-Z) into the timed on/off
// keying waveform on key_out. Every interval is counted in Morse units,
// each marked by a one-cycle tick from the shared prescaler.
module morse_tx #(
    parameter int DOT_UNITS  = 1,
    parameter int DASH_UNITS = 3,
    parameter int SYM_GAP    = 1,
    parameter int CHAR_GAP   = 3,
    parameter int CNT_BITS   = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       start,
    input  logic [4:0] char,
    output logic       key_out,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {IDLE, MARK, SPACE, CGAP} state_t;

    localparam logic [CNT_BITS-1:0] DOT_CNT   = CNT_BITS'(DOT_UNITS);
    localparam logic [CNT_BITS-1:0] DASH_CNT  = CNT_BITS'(DASH_UNITS);
    localparam logic [CNT_BITS-1:0] SYM_CNT   = CNT_BITS'(SYM_GAP);
    localparam logic [CNT_BITS-1:0] CGAP_CNT  = CNT_BITS'(CHAR_GAP);
    localparam logic [CNT_BITS-1:0] ONE       = CNT_BITS'(1);

    // Code ROM: {index of last symbol, pattern}; pattern is MSB-first,
    // left-aligned, 1 = dash, 0 = dot.
    function automatic logic [5:0] code_rom(input logic [4:0] c);
        case (c)
            5'd0:    code_rom = {2'd1, 4'b0100};  // A .-
            5'd1:    code_rom = {2'd3, 4'b1000};  // B -...
            5'd2:    code_rom = {2'd3, 4'b1010};  // C -.-.
            5'd3:    code_rom = {2'd2, 4'b1000};  // D -..
            5'd4:    code_rom = {2'd0, 4'b0000};  // E .
            5'd5:    code_rom = {2'd3, 4'b0010};  // F ..-.
            5'd6:    code_rom = {2'd2, 4'b1100};  // G --.
            5'd7:    code_rom = {2'd3, 4'b0000};  // H ....
            5'd8:    code_rom = {2'd1, 4'b0000};  // I ..
            5'd9:    code_rom = {2'd3, 4'b0111};  // J .---
            5'd10:   code_rom = {2'd2, 4'b1010};  // K -.-
            5'd11:   code_rom = {2'd3, 4'b0100};  // L .-..
            5'd12:   code_rom = {2'd1, 4'b1100};  // M --
            5'd13:   code_rom = {2'd1, 4'b1000};  // N -.
            5'd14:   code_rom = {2'd2, 4'b1110};  // O ---
            5'd15:   code_rom = {2'd3, 4'b0110};  // P .--.
            5'd16:   code_rom = {2'd3, 4'b1101};  // Q --.-
            5'd17:   code_rom = {2'd2, 4'b0100};  // R .-.
            5'd18:   code_rom = {2'd2, 4'b0000};  // S ...
            5'd19:   code_rom = {2'd0, 4'b1000};  // T -
            5'd20:   code_rom = {2'd2, 4'b0010};  // U ..-
            5'd21:   code_rom = {2'd3, 4'b0001};  // V ...-
            5'd22:   code_rom = {2'd2, 4'b0110};  // W .--
            5'd23:   code_rom = {2'd3, 4'b1001};  // X -..-
            5'd24:   code_rom = {2'd3, 4'b1011};  // Y -.--
            5'd25:   code_rom = {2'd3, 4'b1100};  // Z --..
            default: code_rom = 6'd0;
        endcase
    endfunction

    state_t              state;
    logic [CNT_BITS-1:0] cnt;
    logic [1:0]          idx;
    logic [1:0]          last_idx;
    logic [3:0]          pattern;

    logic [5:0] rom_entry;
    logic       char_valid;
    logic [1:0] next_idx;
    logic       next_dash;

    // ROM lookup for the incoming char and the next symbol of the latched code.
    always_comb begin
        rom_entry  = code_rom(char);
        char_valid = (char <= 5'd25);
        next_idx   = idx + 2'd1;
        next_dash  = pattern[2'd3 - next_idx];
    end

    // Keying FSM: every output is a register updated together with the state.
    // NOTE: all state is assigned with <= so every register samples the
    // pre-edge values; mixing in blocking writes here would make the result
    // depend on statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            last_idx <= '0;
            pattern  <= '0;
            key_out  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (char_valid) begin
                            last_idx <= rom_entry[5:4];
                            pattern  <= rom_entry[3:0];
                            idx      <= '0;
                            cnt      <= rom_entry[3] ? DASH_CNT : DOT_CNT;
                            state    <= MARK;
                            key_out  <= 1'b1;
                            busy     <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                MARK: begin
                    if (tick) begin
                        if (cnt != ONE) begin
                            cnt <= cnt - ONE;
                        end else begin
                            key_out <= 1'b0;
                            if (idx == last_idx) begin
                                state <= CGAP;
                                cnt   <= CGAP_CNT;
                            end else begin
                                state <= SPACE;
                                cnt   <= SYM_CNT;
                            end
                        end
                    end
                end
                SPACE: begin
                    if (tick) begin
                        if (cnt != ONE) begin
                            cnt <= cnt - ONE;
                        end else begin
                            idx     <= next_idx;
                            cnt     <= next_dash ? DASH_CNT : DOT_CNT;
                            state   <= MARK;
                            key_out <= 1'b1;
                        end
                    end
                end
                CGAP: begin
                    if (tick) begin
                        if (cnt != ONE) begin
                            cnt <= cnt - ONE;
                        end else begin
                            cnt   <= '0;
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    key_out <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_morse_tx.sv
// Testbench for morse_tx: directed characters, expected keying patterns
// (one bit per Morse unit) queued at stimulus time and compared by a
// monitor whenever the DUT pulses done or err.
module tb_morse_tx;

    logic       clk;
    logic       reset_n;
    logic       tick;
    logic       start;
    logic [4:0] char;
    logic       key_out;
    logic       busy;
    logic       done;
    logic       err;

    morse_tx dut (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick),
        .start   (start),
        .char    (char),
        .key_out (key_out),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    typedef struct {
        bit          is_err;
        logic [63:0] bits;
        int          len;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int tick_mode = 1;   // 0 = never, 1 = every cycle, otherwise every 4th cycle
    int tick_phase = 0;

    logic [63:0] seen_bits = '0;
    int          seen_len  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Tick generator, updated just after each rising edge.
    always @(posedge clk) begin
        #1;
        tick_phase++;
        if (tick_mode == 0)      tick = 1'b0;
        else if (tick_mode == 1) tick = 1'b1;
        else                     tick = (tick_phase % 4 == 0);
    end

    // Monitor: records key_out once per unit (tick cycles while busy) and
    // checks the collected pattern against the scoreboard on done/err.
    always @(negedge clk) begin
        if (!reset_n) begin
            seen_bits = '0;
            seen_len  = 0;
        end else begin
            if (busy && tick) begin
                seen_bits = {seen_bits[62:0], key_out};
                seen_len++;
            end
            if (done || err) begin
                if (exp_q.size() == 0) begin
                    check("spurious_event", {62'd0, done, err}, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("event_kind", {63'd0, err}, {63'd0, e.is_err});
                    check("event_exclusive", {63'd0, done & err}, 64'd0);
                    check("busy_at_event", {63'd0, busy}, 64'd0);
                    check("key_at_event", {63'd0, key_out}, 64'd0);
                    if (!e.is_err) begin
                        check("unit_pattern", seen_bits, e.bits);
                        check("unit_count", 64'(seen_len), 64'(e.len));
                    end
                end
                seen_bits = '0;
                seen_len  = 0;
            end
        end
    end

    // Pulse start for one cycle; optionally queue the expected outcome.
    task automatic send(input logic [4:0] c, input bit push, input bit is_err,
                        input logic [63:0] bits, input int len);
        exp_t e;
        if (push) begin
            e.is_err = is_err;
            e.bits   = bits;
            e.len    = len;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b1;
        char  = c;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        reset_n = 1'b0;
        start   = 1'b0;
        char    = 5'd0;
        tick    = 1'b0;

        // Reset state
        #23;
        check("rst_key", {63'd0, key_out}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_err", {63'd0, err}, 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // E with tick held: 1 unit on, 3 off; key_out visible the cycle after start
        tick_mode = 1;
        send(5'd4, 1'b1, 1'b0, 64'h8, 4);
        check("e_latency_key", {63'd0, key_out}, 64'd1);
        check("e_latency_busy", {63'd0, busy}, 64'd1);
        @(posedge clk); #1;
        check("e_key_second_cycle", {63'd0, key_out}, 64'd0);
        wait_drain("e_timeout", 50);

        // A: .-
        send(5'd0, 1'b1, 1'b0, 64'hB8, 8);
        wait_drain("a_timeout", 50);

        // T with sparse tick: 3 units on, 3 off
        tick_mode = 4;
        send(5'd19, 1'b1, 1'b0, 64'h38, 6);
        wait_drain("t_timeout", 100);

        // Invalid codes: err for one cycle, nothing else moves
        tick_mode = 1;
        send(5'd27, 1'b1, 1'b1, 64'd0, 0);
        check("err27_pulse", {63'd0, err}, 64'd1);
        check("err27_busy", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
        check("err27_one_cycle", {63'd0, err}, 64'd0);
        check("err27_key", {63'd0, key_out}, 64'd0);
        send(5'd26, 1'b1, 1'b1, 64'd0, 0);
        check("err26_pulse", {63'd0, err}, 64'd1);
        wait_drain("err_timeout", 10);

        // Q with a start (and char change) mid-transfer, then E back-to-back
        send(5'd16, 1'b1, 1'b0, 64'hEEB8, 16);
        repeat (4) @(posedge clk);
        #1;
        send(5'd4, 1'b0, 1'b0, 64'd0, 0);
        check("q_busy_after_ignored_start", {63'd0, busy}, 64'd1);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!done && n < 100);
        check("q_done_seen", {63'd0, done}, 64'd1);
        begin
            exp_t e;
            e.is_err = 1'b0;
            e.bits   = 64'h8;
            e.len    = 4;
            exp_q.push_back(e);
        end
        start = 1'b1;
        char  = 5'd4;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_key", {63'd0, key_out}, 64'd1);
        wait_drain("b2b_timeout", 50);

        // Reset during the first dash of Q: abandoned, no done
        send(5'd16, 1'b0, 1'b0, 64'd0, 0);
        @(posedge clk); #1;
        check("mid_mark_key", {63'd0, key_out}, 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_key", {63'd0, key_out}, 64'd0);
        check("async_rst_busy", {63'd0, busy}, 64'd0);
        check("async_rst_done", {63'd0, done}, 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_busy", {63'd0, busy}, 64'd0);

        // Z (highest valid index) after reset
        send(5'd25, 1'b1, 1'b0, 64'h3BA8, 14);
        wait_drain("z_timeout", 60);

        repeat (5) @(posedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
